// File: rtl/mapping_group_seq_ctrl.sv
// Sequencer for one mapping-group output datapath (encoder -> buffer -> shifter -> accum -> ZP add).
// Latency: an accepted start reaches LOAD after NUM_ITER iterations (4 cycles RBR, 6 PARALLEL, + 1 cycle).
// Backpressure: WAIT1/WAIT2 stall on pim_valid_i; LOAD stalls on out_ready_i; abort_i drops the operation.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i, mode_i           start request and mode (3'b101 PARALLEL, 3'b110 RBR), sampled in IDLE
//   abort_i                   abandon the current operation
//   pim_valid_i, out_ready_i  PIM macro output valid / downstream consumer ready
//   cfg_zp_we_i, cfg_zp_data_i zero-point write request and value
//   pim_mode_o                mode latched at start, held for the whole operation
//   buf_write_en_1/2_o        capture PIM output into buffer slot 1 / slot 2
//   buf_read_en_o, proc_done_o shifter read strobe / output_processing_done
//   load_en_o, zp_en_o, zp_data_o  result load strobe, zero-point load strobe and data
//   busy_o, iter_o, done_o, err_o  status: non-IDLE, completed iterations, done pulse, error pulse
module mapping_group_seq_ctrl #(
    parameter int NUM_ITER = 8,
    parameter int ITER_W   = $clog2(NUM_ITER + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [2:0]        mode_i,
    input  logic              abort_i,
    input  logic              pim_valid_i,
    input  logic              out_ready_i,
    input  logic              cfg_zp_we_i,
    input  logic [31:0]       cfg_zp_data_i,
    output logic [2:0]        pim_mode_o,
    output logic              buf_write_en_1_o,
    output logic              buf_write_en_2_o,
    output logic              buf_read_en_o,
    output logic              proc_done_o,
    output logic              load_en_o,
    output logic              zp_en_o,
    output logic [31:0]       zp_data_o,
    output logic              busy_o,
    output logic [ITER_W-1:0] iter_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT1 = 3'd1;
    localparam logic [2:0] S_WR1   = 3'd2;
    localparam logic [2:0] S_WAIT2 = 3'd3;
    localparam logic [2:0] S_WR2   = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_PROC  = 3'd6;
    localparam logic [2:0] S_LOAD  = 3'd7;

    localparam logic [2:0] MODE_PAR = 3'b101;
    localparam logic [2:0] MODE_RBR = 3'b110;

    // iter_q holds completed iterations, so PROC with this value is the final one.
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(NUM_ITER - 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ITER_W-1:0] iter_q;
    logic [2:0]        mode_q;
    logic              done_q;
    logic              err_q;

    logic is_idle;
    logic mode_ok;
    logic start_acc;
    logic abort_act;
    logic live;
    logic zp_drop;
    logic err_d;
    logic load_fire;

    assign is_idle   = (state_q == S_IDLE);
    assign mode_ok   = (mode_i == MODE_PAR) || (mode_i == MODE_RBR);
    assign start_acc = is_idle && start_i && mode_ok;
    assign abort_act = abort_i && !is_idle;

    // Strobes are suppressed in a reset cycle and in an abort cycle.
    assign live = !rst_i && !abort_act;

    // A ZP write is only honoured in a quiet IDLE cycle; a concurrent start wins.
    assign zp_drop   = cfg_zp_we_i && (!is_idle || start_i);
    assign err_d     = (is_idle && start_i && !mode_ok) || zp_drop;
    assign load_fire = (state_q == S_LOAD) && out_ready_i && !abort_act;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_acc) state_d = S_WAIT1;
            S_WAIT1: if (pim_valid_i) state_d = S_WR1;
            S_WR1:   state_d = (mode_q == MODE_PAR) ? S_WAIT2 : S_READ;
            S_WAIT2: if (pim_valid_i) state_d = S_WR2;
            S_WR2:   state_d = S_READ;
            S_READ:  state_d = S_PROC;
            S_PROC:  state_d = (iter_q == ITER_LAST) ? S_LOAD : S_WAIT1;
            S_LOAD:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            iter_q  <= '0;
            mode_q  <= 3'b000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= load_fire;
            err_q   <= err_d;
            if (start_acc) begin
                mode_q <= mode_i;
                iter_q <= '0;
            end else if (abort_act) begin
                iter_q <= '0;
            end else if (state_q == S_PROC) begin
                iter_q <= iter_q + 1'b1;
            end
        end
    end

    assign buf_write_en_1_o = live && (state_q == S_WR1);
    assign buf_write_en_2_o = live && (state_q == S_WR2);
    assign buf_read_en_o    = live && (state_q == S_READ);
    assign proc_done_o      = live && (state_q == S_PROC);
    assign load_en_o        = live && (state_q == S_LOAD) && out_ready_i;
    assign zp_en_o          = !rst_i && cfg_zp_we_i && is_idle && !start_i;
    assign zp_data_o        = cfg_zp_data_i;

    assign pim_mode_o = mode_q;
    assign busy_o     = !is_idle;
    assign iter_o     = iter_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_mapping_group_seq_ctrl.sv
// Bench for mapping_group_seq_ctrl: two instances (NUM_ITER=8 and NUM_ITER=1).
// Expected strobe events are queued at stimulus time; a negedge monitor pops and compares.
// Every cycle with any strobe/pulse asserted is an event that must match the queue head.
module tb_mapping_group_seq_ctrl;

    localparam logic [2:0] PAR  = 3'b101;
    localparam logic [2:0] RBR  = 3'b110;
    localparam logic [2:0] BADM = 3'b000;

    // Event bit vector order: {wr1, wr2, read, proc, load, zp_en, done, err}
    localparam logic [7:0] WR1 = 8'h80;
    localparam logic [7:0] WR2 = 8'h40;
    localparam logic [7:0] RD  = 8'h20;
    localparam logic [7:0] PRC = 8'h10;
    localparam logic [7:0] LD  = 8'h08;
    localparam logic [7:0] ZP  = 8'h04;
    localparam logic [7:0] DN  = 8'h02;
    localparam logic [7:0] ER  = 8'h01;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  stb;
        logic [2:0]  mode;
        logic [3:0]  iter;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  t0    = 0;
    bit  mon_en = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A (NUM_ITER = 8)
    logic        start_a = 0, abort_a = 0, valid_a = 0, ready_a = 0, zp_we_a = 0;
    logic [2:0]  mode_in_a = 0;
    logic [31:0] zp_dat_a = 0;
    logic [2:0]  mode_a;
    logic        wr1_a, wr2_a, rd_a, proc_a, load_a, zp_a, busy_a, done_a, err_a;
    logic [31:0] zp_out_a;
    logic [3:0]  iter_a;

    // DUT B (NUM_ITER = 1)
    logic        start_b = 0, abort_b = 0, valid_b = 0, ready_b = 0, zp_we_b = 0;
    logic [2:0]  mode_in_b = 0;
    logic [31:0] zp_dat_b = 0;
    logic [2:0]  mode_b;
    logic        wr1_b, wr2_b, rd_b, proc_b, load_b, zp_b, busy_b, done_b, err_b;
    logic [31:0] zp_out_b;
    logic [0:0]  iter_b;

    mapping_group_seq_ctrl #(.NUM_ITER(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .mode_i(mode_in_a), .abort_i(abort_a),
        .pim_valid_i(valid_a), .out_ready_i(ready_a), .cfg_zp_we_i(zp_we_a), .cfg_zp_data_i(zp_dat_a),
        .pim_mode_o(mode_a), .buf_write_en_1_o(wr1_a), .buf_write_en_2_o(wr2_a), .buf_read_en_o(rd_a),
        .proc_done_o(proc_a), .load_en_o(load_a), .zp_en_o(zp_a), .zp_data_o(zp_out_a),
        .busy_o(busy_a), .iter_o(iter_a), .done_o(done_a), .err_o(err_a)
    );

    mapping_group_seq_ctrl #(.NUM_ITER(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_i(mode_in_b), .abort_i(abort_b),
        .pim_valid_i(valid_b), .out_ready_i(ready_b), .cfg_zp_we_i(zp_we_b), .cfg_zp_data_i(zp_dat_b),
        .pim_mode_o(mode_b), .buf_write_en_1_o(wr1_b), .buf_write_en_2_o(wr2_b), .buf_read_en_o(rd_b),
        .proc_done_o(proc_b), .load_en_o(load_b), .zp_en_o(zp_b), .zp_data_o(zp_out_b),
        .busy_o(busy_b), .iter_o(iter_b), .done_o(done_b), .err_o(err_b)
    );

    task automatic push(input int id, input int c, input logic [7:0] s, input logic [2:0] m, input int it);
        ev_t e;
        e.cyc  = c;
        e.stb  = s;
        e.mode = m;
        e.iter = it[3:0];
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic observe(input int id, input ev_t got);
        ev_t e;
        total++;
        if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_event dut%0d: got cyc=%0d stb=%b mode=%b iter=%0d, none expected",
                     id, got.cyc, got.stb, got.mode, got.iter);
        end else begin
            if (id == 0) e = qa.pop_front();
            else         e = qb.pop_front();
            if (got !== e) begin
                bad++;
                $display("FAIL event dut%0d: got cyc=%0d stb=%b mode=%b iter=%0d expected cyc=%0d stb=%b mode=%b iter=%0d",
                         id, got.cyc, got.stb, got.mode, got.iter, e.cyc, e.stb, e.mode, e.iter);
            end
        end
    endtask

    // Advance to just after the posedge that starts cycle c.
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        ev_t g;
        if (mon_en) begin
            g.cyc  = cyc;
            g.stb  = {wr1_a, wr2_a, rd_a, proc_a, load_a, zp_a, done_a, err_a};
            g.mode = mode_a;
            g.iter = iter_a;
            if (g.stb != 8'h00) observe(0, g);
            g.stb  = {wr1_b, wr2_b, rd_b, proc_b, load_b, zp_b, done_b, err_b};
            g.mode = mode_b;
            g.iter = {3'b000, iter_b};
            if (g.stb != 8'h00) observe(1, g);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        at(3);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy", {31'b0, busy_a}, 0);
        chk("rst_mode", {29'b0, mode_a}, 0);
        chk("rst_iter", {28'b0, iter_a}, 0);
        chk("rst_strobes", {24'b0, wr1_a, wr2_a, rd_a, proc_a, load_a, zp_a, done_a, err_a}, 0);
        chk("rst_busy_b", {31'b0, busy_b}, 0);

        // NUM_ITER=1, RBR, ZP write coinciding with start (dropped, err)
        at(cyc + 2);
        valid_b = 1; ready_b = 1;
        t0 = cyc;
        start_b = 1; mode_in_b = RBR; zp_we_b = 1; zp_dat_b = 32'h0000_1234;
        push(1, t0 + 1, ER,  RBR, 0);
        push(1, t0 + 2, WR1, RBR, 0);
        push(1, t0 + 3, RD,  RBR, 0);
        push(1, t0 + 4, PRC, RBR, 0);
        push(1, t0 + 5, LD,  RBR, 1);
        push(1, t0 + 6, DN,  RBR, 1);
        chk("zp_data_b", zp_out_b, 32'h0000_1234);
        at(t0 + 1); start_b = 0; zp_we_b = 0;
        at(t0 + 2); chk("n1_busy", {31'b0, busy_b}, 1);
        at(t0 + 8); chk("n1_idle", {31'b0, busy_b}, 0);

        // NUM_ITER=1, PARALLEL with 3-cycle valid stall in WAIT2 and 5-cycle ready stall in LOAD
        ready_b = 0; valid_b = 1;
        t0 = cyc;
        start_b = 1; mode_in_b = PAR;
        push(1, t0 + 2,  WR1, PAR, 0);
        push(1, t0 + 7,  WR2, PAR, 0);
        push(1, t0 + 8,  RD,  PAR, 0);
        push(1, t0 + 9,  PRC, PAR, 0);
        push(1, t0 + 15, LD,  PAR, 1);
        push(1, t0 + 16, DN,  PAR, 1);
        at(t0 + 1);  start_b = 0;
        at(t0 + 3);  valid_b = 0;
        at(t0 + 6);  valid_b = 1;
        at(t0 + 12); chk("stall_busy", {31'b0, busy_b}, 1);
        at(t0 + 15); ready_b = 1;
        at(t0 + 18); chk("stall_idle", {31'b0, busy_b}, 0);
        valid_b = 0;

        // NUM_ITER=8, RBR, start while busy ignored
        valid_a = 1; ready_a = 1;
        t0 = cyc;
        start_a = 1; mode_in_a = RBR;
        for (int i = 0; i < 8; i++) begin
            push(0, t0 + 2 + 4 * i, WR1, RBR, i);
            push(0, t0 + 3 + 4 * i, RD,  RBR, i);
            push(0, t0 + 4 + 4 * i, PRC, RBR, i);
        end
        push(0, t0 + 33, LD, RBR, 8);
        push(0, t0 + 34, DN, RBR, 8);
        at(t0 + 1);  start_a = 0;
        at(t0 + 10); start_a = 1; mode_in_a = PAR;
        at(t0 + 11); start_a = 0; mode_in_a = RBR;
        at(t0 + 33); chk("rbr_iter_at_load", {28'b0, iter_a}, 8);
        at(t0 + 36); chk("rbr_idle", {31'b0, busy_a}, 0);

        // NUM_ITER=8, PARALLEL, ZP write while busy (dropped, err)
        t0 = cyc;
        start_a = 1; mode_in_a = PAR;
        for (int i = 0; i < 8; i++) begin
            push(0, t0 + 2 + 6 * i, WR1, PAR, i);
            if (i == 1) push(0, t0 + 9, ER, PAR, 1);
            push(0, t0 + 4 + 6 * i, WR2, PAR, i);
            push(0, t0 + 5 + 6 * i, RD,  PAR, i);
            push(0, t0 + 6 + 6 * i, PRC, PAR, i);
        end
        push(0, t0 + 49, LD, PAR, 8);
        push(0, t0 + 50, DN, PAR, 8);
        at(t0 + 1); start_a = 0;
        at(t0 + 8); zp_we_a = 1; zp_dat_a = 32'hFFFF_FF80;
        at(t0 + 9); zp_we_a = 0;
        at(t0 + 52); chk("par_idle", {31'b0, busy_a}, 0);

        // Invalid mode at start
        t0 = cyc;
        start_a = 1; mode_in_a = BADM;
        push(0, t0 + 1, ER, PAR, 8);
        at(t0 + 1); start_a = 0;
        chk("badmode_busy1", {31'b0, busy_a}, 0);
        at(t0 + 2);
        chk("badmode_busy2", {31'b0, busy_a}, 0);
        chk("badmode_mode", {29'b0, mode_a}, {29'b0, PAR});

        // Abort in PROC of the third iteration
        t0 = cyc;
        start_a = 1; mode_in_a = RBR;
        for (int i = 0; i < 2; i++) begin
            push(0, t0 + 2 + 4 * i, WR1, RBR, i);
            push(0, t0 + 3 + 4 * i, RD,  RBR, i);
            push(0, t0 + 4 + 4 * i, PRC, RBR, i);
        end
        push(0, t0 + 10, WR1, RBR, 2);
        push(0, t0 + 11, RD,  RBR, 2);
        at(t0 + 1);  start_a = 0;
        at(t0 + 12); abort_a = 1;
        at(t0 + 13); abort_a = 0;
        chk("abort_busy", {31'b0, busy_a}, 0);
        chk("abort_iter", {28'b0, iter_a}, 0);
        chk("abort_mode", {29'b0, mode_a}, {29'b0, RBR});
        at(t0 + 40);

        // Synchronous reset in PROC of the third iteration
        t0 = cyc;
        start_a = 1; mode_in_a = RBR;
        for (int i = 0; i < 2; i++) begin
            push(0, t0 + 2 + 4 * i, WR1, RBR, i);
            push(0, t0 + 3 + 4 * i, RD,  RBR, i);
            push(0, t0 + 4 + 4 * i, PRC, RBR, i);
        end
        push(0, t0 + 10, WR1, RBR, 2);
        push(0, t0 + 11, RD,  RBR, 2);
        at(t0 + 1);  start_a = 0;
        at(t0 + 12); rst = 1;
        at(t0 + 13); rst = 0;
        chk("srst_busy", {31'b0, busy_a}, 0);
        chk("srst_iter", {28'b0, iter_a}, 0);
        chk("srst_mode", {29'b0, mode_a}, 0);
        at(t0 + 40);

        // ZP write in IDLE
        t0 = cyc;
        zp_we_a = 1; zp_dat_a = 32'hFFFF_FF80;
        push(0, t0, ZP, 3'b000, 0);
        chk("zp_data_neg128", zp_out_a, 32'(-128));
        at(t0 + 1); zp_we_a = 0;
        at(t0 + 4);

        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
